// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microcode sequencer driving the registered datapath control word
// Walks the fetch page, then the opcode page, one microword per clock.
module control_sequencer #(
  parameter int SIG_WIDTH  = 42,
  parameter int OPC_WIDTH  = 8,
  parameter int STEP_WIDTH = 4,
  parameter logic [OPC_WIDTH-1:0] FETCH_PAGE = 8'hFF,
  parameter int UW_WIDTH   = SIG_WIDTH + 7
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [OPC_WIDTH-1:0]            bus_in,
  input  logic [7:0]                      flags,
  input  logic                            mem_ready,
  output logic [OPC_WIDTH+STEP_WIDTH-1:0] ucode_addr,
  input  logic [UW_WIDTH-1:0]             ucode_data,
  output logic [SIG_WIDTH-1:0]            signals,
  output logic [OPC_WIDTH-1:0]            opcode,
  output logic                            halted,
  output logic                            ucode_overflow
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [STEP_WIDTH-1:0]  step_q, step_d;
  logic [SIG_WIDTH-1:0]   signals_d;
  logic [OPC_WIDTH-1:0]   opcode_d;
  logic                   overflow_d;

  logic [SIG_WIDTH-1:0]   uw_sig;
  logic                   uw_end;
  logic                   uw_wait;
  logic [2:0]             uw_csel;
  logic                   uw_cen;
  logic                   uw_halt;
  logic                   cond_abort;
  logic                   last_step;

  assign uw_sig     = ucode_data[SIG_WIDTH-1:0];
  assign uw_end     = ucode_data[SIG_WIDTH];
  assign uw_wait    = ucode_data[SIG_WIDTH+1];
  assign uw_csel    = ucode_data[SIG_WIDTH+4:SIG_WIDTH+2];
  assign uw_cen     = ucode_data[SIG_WIDTH+5];
  assign uw_halt    = ucode_data[SIG_WIDTH+6];
  assign cond_abort = uw_cen && !flags[uw_csel];
  assign last_step  = (step_q == {STEP_WIDTH{1'b1}});
  assign halted     = (state_q == HALTED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= FETCH;
      step_q         <= '0;
      signals        <= '0;
      opcode         <= '0;
      ucode_overflow <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      signals        <= signals_d;
      opcode         <= opcode_d;
      ucode_overflow <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    signals_d  = signals;
    opcode_d   = opcode;
    overflow_d = ucode_overflow;
    ucode_addr = {FETCH_PAGE, {STEP_WIDTH{1'b0}}};
    case (state_q)
      FETCH, EXEC: begin
        ucode_addr = {(state_q == EXEC) ? opcode : FETCH_PAGE, step_q};
        signals_d  = uw_sig;
        if (uw_halt) begin
          // HALT overrides END and WAIT; the datapath is quiesced on entry
          state_d   = HALTED;
          step_d    = '0;
          signals_d = '0;
        end else if (uw_wait && !mem_ready) begin
          step_d = step_q;
        end else if (cond_abort || uw_end || last_step) begin
          step_d  = '0;
          state_d = (state_q == FETCH) ? DECODE : FETCH;
          if (!cond_abort && !uw_end) overflow_d = 1'b1;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DECODE: begin
        opcode_d  = bus_in;
        signals_d = '0;
        step_d    = '0;
        state_d   = EXEC;
      end
      HALTED: begin
        signals_d = '0;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
// The bench owns the ROM image and the expected address/signal timeline.
module tb_control_sequencer;

  logic        clk;
  logic        reset;
  logic [7:0]  bus_in;
  logic [7:0]  flags;
  logic        mem_ready;
  logic [11:0] ucode_addr;
  logic [48:0] ucode_data;
  logic [41:0] signals;
  logic [7:0]  opcode;
  logic        halted;
  logic        ucode_overflow;

  logic [48:0] rom [4096];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [11:0] addr;
    logic [41:0] sig;
    logic [7:0]  opc;
    logic [7:0]  bus;
    logic        rdy;
    logic        ovf;
    logic        hlt;
  } exp_t;

  exp_t sb[$];

  control_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .bus_in         (bus_in),
    .flags          (flags),
    .mem_ready      (mem_ready),
    .ucode_addr     (ucode_addr),
    .ucode_data     (ucode_data),
    .signals        (signals),
    .opcode         (opcode),
    .halted         (halted),
    .ucode_overflow (ucode_overflow)
  );

  assign ucode_data = rom[ucode_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [41:0] sg(input logic [11:0] a);
    return {a, a, a, 6'h2A};
  endfunction

  function automatic logic [48:0] mk(input logic [11:0] a, input logic e, input logic w,
                                     input logic [2:0] cs, input logic c, input logic h);
    return {h, c, cs, w, e, sg(a)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic push(input logic [11:0] a, input logic [41:0] s, input logic [7:0] o,
                      input logic [7:0] b, input logic r = 1'b1, input logic ov = 1'b0,
                      input logic h = 1'b0);
    exp_t e;
    e.addr = a; e.sig = s; e.opc = o; e.bus = b; e.rdy = r; e.ovf = ov; e.hlt = h;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    logic first;
    exp_t e;
    reset = 1'b0;
    #2;
    n_tests++;
    if ({signals, opcode, ucode_addr, halted, ucode_overflow} !== {42'h0, 8'h00, 12'hFF0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state sig=%h opc=%h addr=%h hlt=%b ovf=%b want 0/00/ff0/0/0",
               signals, opcode, ucode_addr, halted, ucode_overflow);
    end
    bus_in = 8'h60; flags = 8'h00; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    push(12'hFF0, 42'h0,        8'h00, 8'h60);
    push(12'hFF1, sg(12'hFF0),  8'h00, 8'h60);
    push(12'hFF0, sg(12'hFF1),  8'h00, 8'h60);
    push(12'h600, 42'h0,        8'h60, 8'h60);
    push(12'h601, {42{1'b1}},   8'h60, 8'h60);
    first = 1'b1;
    while (sb.size() > 0) begin
      if (!first) tick();
      first = 1'b0;
      e = sb.pop_front();
      n_tests++;
      if ({ucode_addr, signals, opcode, ucode_overflow, halted} !== {e.addr, e.sig, e.opc, e.ovf, e.hlt}) begin
        n_fail++;
        $display("FAIL reset_seq addr=%h sig=%h opc=%h ovf=%b hlt=%b want addr=%h sig=%h opc=%h ovf=%b hlt=%b",
                 ucode_addr, signals, opcode, ucode_overflow, halted, e.addr, e.sig, e.opc, e.ovf, e.hlt);
      end
      mem_ready = e.rdy;
      bus_in = e.bus;
    end
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (signals !== 42'h0) begin
      n_fail++;
      $display("FAIL async_reset_signals got %h want 0", signals);
    end
    n_tests++;
    if (opcode !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset_opcode got %h want 00", opcode);
    end
    n_tests++;
    if (ucode_addr !== 12'hFF0) begin
      n_fail++;
      $display("FAIL async_reset_addr got %h want ff0", ucode_addr);
    end
    reset = 1'b1;
    tick();
    n_tests++;
    if ({signals, ucode_addr} !== {sg(12'hFF0), 12'hFF1}) begin
      n_fail++;
      $display("FAIL first_edge_after_reset sig=%h addr=%h want sig=%h addr=ff1",
               signals, ucode_addr, sg(12'hFF0));
    end
  endtask

  task automatic test_back_to_back();
    logic first;
    exp_t e;
    bus_in = 8'h12; flags = 8'h04; mem_ready = 1'b1;
    do_reset();
    push(12'hFF0, 42'h0,       8'h00, 8'h12);
    push(12'hFF1, sg(12'hFF0), 8'h00, 8'h12);
    push(12'hFF0, sg(12'hFF1), 8'h00, 8'h12);
    push(12'h120, 42'h0,       8'h12, 8'h12);
    push(12'h121, sg(12'h120), 8'h12, 8'h12);
    push(12'h122, sg(12'h121), 8'h12, 8'h20);
    push(12'hFF0, sg(12'h122), 8'h12, 8'h20);
    push(12'hFF1, sg(12'hFF0), 8'h12, 8'h20);
    push(12'hFF0, sg(12'hFF1), 8'h12, 8'h20);
    push(12'h200, 42'h0,       8'h20, 8'h20);
    push(12'h201, sg(12'h200), 8'h20, 8'h20);
    push(12'hFF0, sg(12'h201), 8'h20, 8'h20);
    first = 1'b1;
    while (sb.size() > 0) begin
      if (!first) tick();
      first = 1'b0;
      e = sb.pop_front();
      n_tests++;
      if ({ucode_addr, signals, opcode, ucode_overflow, halted} !== {e.addr, e.sig, e.opc, e.ovf, e.hlt}) begin
        n_fail++;
        $display("FAIL back_to_back addr=%h sig=%h opc=%h ovf=%b hlt=%b want addr=%h sig=%h opc=%h ovf=%b hlt=%b",
                 ucode_addr, signals, opcode, ucode_overflow, halted, e.addr, e.sig, e.opc, e.ovf, e.hlt);
      end
      mem_ready = e.rdy;
      bus_in = e.bus;
    end
  endtask

  task automatic test_cond_abort();
    logic first;
    exp_t e;
    bus_in = 8'h20; flags = 8'h00; mem_ready = 1'b1;
    do_reset();
    push(12'hFF0, 42'h0,       8'h00, 8'h20);
    push(12'hFF1, sg(12'hFF0), 8'h00, 8'h20);
    push(12'hFF0, sg(12'hFF1), 8'h00, 8'h20);
    push(12'h200, 42'h0,       8'h20, 8'h20);
    push(12'hFF0, sg(12'h200), 8'h20, 8'h20);
    push(12'hFF1, sg(12'hFF0), 8'h20, 8'h20);
    first = 1'b1;
    while (sb.size() > 0) begin
      if (!first) tick();
      first = 1'b0;
      e = sb.pop_front();
      n_tests++;
      if ({ucode_addr, signals, opcode, ucode_overflow, halted} !== {e.addr, e.sig, e.opc, e.ovf, e.hlt}) begin
        n_fail++;
        $display("FAIL cond_abort addr=%h sig=%h opc=%h ovf=%b hlt=%b want addr=%h sig=%h opc=%h ovf=%b hlt=%b",
                 ucode_addr, signals, opcode, ucode_overflow, halted, e.addr, e.sig, e.opc, e.ovf, e.hlt);
      end
      mem_ready = e.rdy;
      bus_in = e.bus;
    end
  endtask

  task automatic test_wait();
    logic first;
    exp_t e;
    rom[12'h121] = mk(12'h121, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
    bus_in = 8'h12; flags = 8'h00; mem_ready = 1'b1;
    do_reset();
    push(12'hFF0, 42'h0,       8'h00, 8'h12);
    push(12'hFF1, sg(12'hFF0), 8'h00, 8'h12);
    push(12'hFF0, sg(12'hFF1), 8'h00, 8'h12);
    push(12'h120, 42'h0,       8'h12, 8'h12);
    push(12'h121, sg(12'h120), 8'h12, 8'h12, 1'b0);
    push(12'h121, sg(12'h121), 8'h12, 8'h12, 1'b0);
    push(12'h121, sg(12'h121), 8'h12, 8'h12, 1'b0);
    push(12'h121, sg(12'h121), 8'h12, 8'h12, 1'b1);
    push(12'h122, sg(12'h121), 8'h12, 8'h12);
    push(12'hFF0, sg(12'h122), 8'h12, 8'h12);
    first = 1'b1;
    while (sb.size() > 0) begin
      if (!first) tick();
      first = 1'b0;
      e = sb.pop_front();
      n_tests++;
      if ({ucode_addr, signals, opcode, ucode_overflow, halted} !== {e.addr, e.sig, e.opc, e.ovf, e.hlt}) begin
        n_fail++;
        $display("FAIL wait_state addr=%h sig=%h opc=%h ovf=%b hlt=%b want addr=%h sig=%h opc=%h ovf=%b hlt=%b",
                 ucode_addr, signals, opcode, ucode_overflow, halted, e.addr, e.sig, e.opc, e.ovf, e.hlt);
      end
      mem_ready = e.rdy;
      bus_in = e.bus;
    end
    rom[12'h121] = mk(12'h121, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    logic first;
    exp_t e;
    bus_in = 8'h30; flags = 8'h00; mem_ready = 1'b1;
    do_reset();
    push(12'hFF0, 42'h0,       8'h00, 8'h30);
    push(12'hFF1, sg(12'hFF0), 8'h00, 8'h30);
    push(12'hFF0, sg(12'hFF1), 8'h00, 8'h30);
    push(12'h300, 42'h0,       8'h30, 8'h12);
    for (int i = 1; i < 16; i++) push(12'h300 + 12'(i), sg(12'h300 + 12'(i - 1)), 8'h30, 8'h12);
    push(12'hFF0, sg(12'h30F), 8'h30, 8'h12, 1'b1, 1'b1);
    push(12'hFF1, sg(12'hFF0), 8'h30, 8'h12, 1'b1, 1'b1);
    push(12'hFF0, sg(12'hFF1), 8'h30, 8'h12, 1'b1, 1'b1);
    push(12'h120, 42'h0,       8'h12, 8'h12, 1'b1, 1'b1);
    push(12'h121, sg(12'h120), 8'h12, 8'h12, 1'b1, 1'b1);
    push(12'h122, sg(12'h121), 8'h12, 8'h12, 1'b1, 1'b1);
    push(12'hFF0, sg(12'h122), 8'h12, 8'h12, 1'b1, 1'b1);
    first = 1'b1;
    while (sb.size() > 0) begin
      if (!first) tick();
      first = 1'b0;
      e = sb.pop_front();
      n_tests++;
      if ({ucode_addr, signals, opcode, ucode_overflow, halted} !== {e.addr, e.sig, e.opc, e.ovf, e.hlt}) begin
        n_fail++;
        $display("FAIL overflow addr=%h sig=%h opc=%h ovf=%b hlt=%b want addr=%h sig=%h opc=%h ovf=%b hlt=%b",
                 ucode_addr, signals, opcode, ucode_overflow, halted, e.addr, e.sig, e.opc, e.ovf, e.hlt);
      end
      mem_ready = e.rdy;
      bus_in = e.bus;
    end
  endtask

  task automatic test_halt();
    logic first;
    exp_t e;
    bus_in = 8'h40; flags = 8'h00; mem_ready = 1'b1;
    do_reset();
    push(12'hFF0, 42'h0,       8'h00, 8'h40);
    push(12'hFF1, sg(12'hFF0), 8'h00, 8'h40);
    push(12'hFF0, sg(12'hFF1), 8'h00, 8'h40);
    push(12'h400, 42'h0,       8'h40, 8'h40, 1'b0);
    for (int i = 0; i < 21; i++)
      push(12'hFF0, 42'h0, 8'h40, 8'($urandom), 1'($urandom), 1'b0, 1'b1);
    first = 1'b1;
    while (sb.size() > 0) begin
      if (!first) tick();
      first = 1'b0;
      e = sb.pop_front();
      n_tests++;
      if ({ucode_addr, signals, opcode, ucode_overflow, halted} !== {e.addr, e.sig, e.opc, e.ovf, e.hlt}) begin
        n_fail++;
        $display("FAIL halt addr=%h sig=%h opc=%h ovf=%b hlt=%b want addr=%h sig=%h opc=%h ovf=%b hlt=%b",
                 ucode_addr, signals, opcode, ucode_overflow, halted, e.addr, e.sig, e.opc, e.ovf, e.hlt);
      end
      mem_ready = e.rdy;
      bus_in = e.bus;
    end
    do_reset();
    n_tests++;
    if ({halted, ucode_addr, signals} !== {1'b0, 12'hFF0, 42'h0}) begin
      n_fail++;
      $display("FAIL halt_exit hlt=%b addr=%h sig=%h want 0/ff0/0", halted, ucode_addr, signals);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus_in = 8'h00;
    flags = 8'h00;
    mem_ready = 1'b1;
    for (int i = 0; i < 4096; i++) rom[i] = mk(12'(i), 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    rom[12'hFF0] = mk(12'hFF0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    rom[12'h120] = mk(12'h120, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    rom[12'h121] = mk(12'h121, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    rom[12'h200] = mk(12'h200, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) rom[12'h300 + i] = mk(12'h300 + 12'(i), 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    rom[12'h400] = mk(12'h400, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
    rom[12'h600] = {7'b0, {42{1'b1}}};
    test_reset();
    test_back_to_back();
    test_cond_abort();
    test_wait();
    test_overflow();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcode sequencer that produces the registered 42-bit `signals` word consumed by the CPU datapath (PC, stack counter, A/B/F registers, ALU, bus buffers).
- Walks a fetch page and then the opcode's microcode page, one microword per clock.
- Handles memory wait states, flag-conditional aborts and halt.
- The microcode ROM is external, with asynchronous read.

Parameters:
- SIG_WIDTH, 42, width of the datapath control word.
- OPC_WIDTH, 8, opcode width, equal to the data bus width.
- STEP_WIDTH, 4, microstep counter width; 16 steps per page.
- FETCH_PAGE, 8'hFF, ROM page holding the fetch microprogram.
- UW_WIDTH, SIG_WIDTH+7, microword width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- bus_in  in  OPC_WIDTH  data bus snoop; the opcode is latched from it.
- flags  in  8  F register contents.
- mem_ready  in  1  memory ready; ends a wait state.
- ucode_addr  out  OPC_WIDTH+STEP_WIDTH  {page, step}; combinational from state.
- ucode_data  in  UW_WIDTH  ROM word at ucode_addr, same cycle.
- signals  out  SIG_WIDTH  registered control word driving the datapath.
- opcode  out  OPC_WIDTH  current instruction register.
- halted  out  1  high in HALTED.
- ucode_overflow  out  1  sticky; a page ran past its last step without END.

Behaviour:
- Microword fields:
  - [SIG_WIDTH-1:0] SIG: control word.
  - [SIG_WIDTH] END: last step of the page.
  - [SIG_WIDTH+1] WAIT: hold until mem_ready.
  - [SIG_WIDTH+4:SIG_WIDTH+2] CSEL: flag index.
  - [SIG_WIDTH+5] CEN: conditional enable.
  - [SIG_WIDTH+6] HALT.
- States: FETCH, DECODE, EXEC, HALTED.
- Page selection: page = FETCH_PAGE in FETCH, page = opcode in EXEC. ucode_addr = {page, step}. In DECODE and HALTED, ucode_addr = {FETCH_PAGE, 0}, and ucode_data is ignored.
- Reset (reset=0, asynchronous): state=FETCH, step=0, opcode=0, signals=0, halted=0, ucode_overflow=0.
- FETCH and EXEC, every edge:
  - signals <= SIG of the current word. The datapath therefore sees a word during the cycle after it was addressed; one cycle of latency.
  - Priority 1: HALT=1 -> HALTED.
  - Priority 2: WAIT=1 and mem_ready=0 -> step holds. SIG is reloaded identically, so signals stay asserted.
  - Priority 3: CEN=1 and flags[CSEL]=0 -> treated as END (conditional abort).
  - Priority 4: END=1 -> step <= 0. FETCH goes to DECODE; EXEC goes to FETCH.
  - Otherwise step <= step+1.
  - If step = all-ones and neither END nor abort applies: treated as END, ucode_overflow <= 1.
- Condition test and END are evaluated after the WAIT clears, i.e. in the cycle mem_ready=1.
- DECODE (exactly 1 cycle):
  - The last fetch word is active on the datapath, so memory is driving the bus.
  - Edge: opcode <= bus_in, signals <= 0, step <= 0, state <= EXEC.
- HALTED:
  - signals <= 0 on entry and stays 0; halted=1.
  - Leaves HALTED only by reset.
  - HALT in the same word as END or WAIT: HALT wins immediately, with no wait.
- Instruction latency: F fetch steps + 1 decode cycle + E exec steps, plus wait cycles.
- Reset mid-instruction: immediate return to reset values, including signals=0 within the same cycle. The first edge after release loads SIG of {FETCH_PAGE, 0}.
- signals never glitches: it is driven from a register only.

Test Plan:
- Reset:
  - Apply reset=0 mid-EXEC with signals=0x3FF_FFFF_FFFF -> signals=0, opcode=0 and ucode_addr=0xFF0 asynchronously.
  - Release reset -> the first edge loads SIG of word 0xFF0.
- Basic instruction:
  - Fetch page: 2 words, END on step 1. bus_in=0x12 during DECODE. Page 0x12: 3 words, END on step 2.
  - -> ucode_addr sequence FF0, FF1, (decode), 120, 121, 122, FF0.
  - -> opcode=0x12 after the DECODE edge; signals trails ucode_addr by one cycle; 6 cycles per instruction.
- Wait state:
  - Exec step 1 has WAIT=1; mem_ready held low for 3 cycles.
  - -> ucode_addr stays at 0x121 for 4 cycles and signals holds that word's SIG; the step advances on the edge with mem_ready=1.
- Conditional abort:
  - Step 0 of page 0x20 has CEN=1, CSEL=2; flags=0x00 -> next address FF0.
  - With flags=0x04 -> next address 0x201.
- Halt:
  - Word with HALT=1 and WAIT=1, mem_ready=0 -> HALTED on the next edge, halted=1, signals=0.
  - Remains there for 20 cycles despite ROM and bus activity.
- Overflow:
  - Page 0x30 with no END -> after step 0xF, returns to FF0 and ucode_overflow=1.
  - ucode_overflow stays 1 through subsequent instructions until reset.
